// File: rtl/bsg_gateway_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// bsg_gateway_cmd_arbiter
//
// Shares one memory-side command/response channel between two BlackParrot
// requesters. Port 0 is mem_cmd/mem_resp, port 1 is io_cmd/io_resp.
// Commands are round-robin arbitrated into a registered output slot. The
// source of every accepted command is pushed into an in-order tag FIFO, so
// responses (which return strictly in command order) can be steered back to
// the requester that issued them. A credit counter bounds the number of
// accepted-but-unresponded commands to max_outstanding_p.
//
// Ports
//   clk_i, reset_i                      clock, synchronous active-high reset
//   mem_cmd_i/_v_i/_ready_o             port 0 command (valid/ready)
//   mem_resp_o/_v_o/_yumi_i             port 0 response (valid/yumi)
//   io_cmd_i/_v_i/_ready_o              port 1 command (valid/ready)
//   io_resp_o/_v_o/_yumi_i              port 1 response (valid/yumi)
//   shared_cmd_o/_v_o/_ready_i          registered arbitrated command
//   shared_resp_i/_v_i/_yumi_o          downstream response
//   outstanding_o                       current credit usage
//   error_o                             sticky: response seen with no tag
// -----------------------------------------------------------------------------
module bsg_gateway_cmd_arbiter #(
    parameter int msg_width_p       = 1,
    parameter int max_outstanding_p = 4
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,

    input  logic [msg_width_p-1:0]                     mem_cmd_i,
    input  logic                                       mem_cmd_v_i,
    output logic                                       mem_cmd_ready_o,
    output logic [msg_width_p-1:0]                     mem_resp_o,
    output logic                                       mem_resp_v_o,
    input  logic                                       mem_resp_yumi_i,

    input  logic [msg_width_p-1:0]                     io_cmd_i,
    input  logic                                       io_cmd_v_i,
    output logic                                       io_cmd_ready_o,
    output logic [msg_width_p-1:0]                     io_resp_o,
    output logic                                       io_resp_v_o,
    input  logic                                       io_resp_yumi_i,

    output logic [msg_width_p-1:0]                     shared_cmd_o,
    output logic                                       shared_cmd_v_o,
    input  logic                                       shared_cmd_ready_i,
    input  logic [msg_width_p-1:0]                     shared_resp_i,
    input  logic                                       shared_resp_v_i,
    output logic                                       shared_resp_yumi_o,

    output logic [$clog2(max_outstanding_p+1)-1:0]     outstanding_o,
    output logic                                       error_o
);

    localparam int CNT_W = $clog2(max_outstanding_p + 1);
    localparam int PTR_W = (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(max_outstanding_p);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(max_outstanding_p - 1);

    // Circular pointer advance; depth need not be a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == LAST_PTR) begin
            next_ptr = '0;
        end else begin
            next_ptr = ptr + PTR_W'(1);
        end
    endfunction

    // State
    logic                       r_cmd_v;
    logic [msg_width_p-1:0]     r_cmd;
    logic                       r_last_grant;   // 1 after reset so port 0 wins the first tie
    logic [max_outstanding_p-1:0] r_tags;       // source id per in-flight command
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [CNT_W-1:0]           r_outstanding;  // doubles as the tag FIFO occupancy
    logic                       r_error;

    // Combinational
    logic                       w_slot_free;
    logic                       w_credit_ok;
    logic                       w_grant0;
    logic                       w_grant1;
    logic                       w_fire;
    logic [msg_width_p-1:0]     w_sel_cmd;
    logic                       w_fifo_empty;
    logic                       w_head;
    logic                       w_route;
    logic                       w_sel_yumi;
    logic                       w_pop;
    logic                       w_drop;

    // Arbitration: a lone requester always wins; on a tie the port that did
    // not win last time gets the grant.
    assign w_slot_free = ~r_cmd_v | shared_cmd_ready_i;
    assign w_credit_ok = (r_outstanding < MAX_CNT);
    assign w_grant0    = mem_cmd_v_i & (~io_cmd_v_i | r_last_grant);
    assign w_grant1    = io_cmd_v_i  & (~mem_cmd_v_i | ~r_last_grant);

    assign mem_cmd_ready_o = w_grant0 & w_slot_free & w_credit_ok;
    assign io_cmd_ready_o  = w_grant1 & w_slot_free & w_credit_ok;
    assign w_fire          = mem_cmd_ready_o | io_cmd_ready_o;
    assign w_sel_cmd       = io_cmd_ready_o ? io_cmd_i : mem_cmd_i;

    // Response steering by the FIFO head tag; with no tag the response is
    // swallowed and flagged instead of being delivered anywhere.
    assign w_fifo_empty = (r_outstanding == '0);
    assign w_head       = r_tags[r_rd_ptr];
    assign w_route      = shared_resp_v_i & ~w_fifo_empty;
    assign w_sel_yumi   = w_head ? io_resp_yumi_i : mem_resp_yumi_i;
    assign w_pop        = w_route & w_sel_yumi;
    assign w_drop       = shared_resp_v_i & w_fifo_empty;

    assign mem_resp_o         = shared_resp_i;
    assign io_resp_o          = shared_resp_i;
    assign mem_resp_v_o       = w_route & ~w_head;
    assign io_resp_v_o        = w_route & w_head;
    assign shared_resp_yumi_o = w_drop | w_pop;

    assign shared_cmd_o   = r_cmd;
    assign shared_cmd_v_o = r_cmd_v;
    assign outstanding_o  = r_outstanding;
    assign error_o        = r_error;

    // Output slot: load on accept, empty once downstream takes it, else hold.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cmd_v      <= 1'b0;
            r_cmd        <= '0;
            r_last_grant <= 1'b1;
        end else if (w_fire) begin
            r_cmd_v      <= 1'b1;
            r_cmd        <= w_sel_cmd;
            r_last_grant <= io_cmd_ready_o;
        end else if (shared_cmd_ready_i) begin
            r_cmd_v      <= 1'b0;
        end else begin
            r_cmd_v      <= r_cmd_v;
        end
    end

    // Tag FIFO and credit count; push and pop may happen in the same cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_tags        <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_fire) begin
                r_tags[r_wr_ptr] <= io_cmd_ready_o;
                r_wr_ptr         <= next_ptr(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_fire, w_pop})
                2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
                2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    // Sticky error for a response that had no matching command.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_error <= 1'b0;
        end else if (w_drop) begin
            r_error <= 1'b1;
        end else begin
            r_error <= r_error;
        end
    end

endmodule

// File: tb/tb_bsg_gateway_cmd_arbiter.sv
// -----------------------------------------------------------------------------
// Testbench for bsg_gateway_cmd_arbiter. A queue-based reference model
// (queue of source ids, a slot flag/value, last winner, sticky error) predicts
// every output each cycle from the behavioural rules; directed sequences and
// a randomized phase drive the DUT.
// -----------------------------------------------------------------------------
module tb_bsg_gateway_cmd_arbiter;

    localparam int W    = 8;
    localparam int MAXO = 4;
    localparam int CW   = $clog2(MAXO + 1);

    logic          clk_i = 1'b0;
    logic          reset_i;
    logic [W-1:0]  mem_cmd_i, io_cmd_i, shared_resp_i;
    logic          mem_cmd_v_i, io_cmd_v_i, shared_cmd_ready_i, shared_resp_v_i;
    logic          mem_resp_yumi_i, io_resp_yumi_i;
    logic          mem_cmd_ready_o, io_cmd_ready_o, mem_resp_v_o, io_resp_v_o;
    logic [W-1:0]  mem_resp_o, io_resp_o, shared_cmd_o;
    logic          shared_cmd_v_o, shared_resp_yumi_o, error_o;
    logic [CW-1:0] outstanding_o;

    always #5 clk_i = ~clk_i;

    bsg_gateway_cmd_arbiter #(.msg_width_p(W), .max_outstanding_p(MAXO)) dut (
        .clk_i              (clk_i),
        .reset_i            (reset_i),
        .mem_cmd_i          (mem_cmd_i),
        .mem_cmd_v_i        (mem_cmd_v_i),
        .mem_cmd_ready_o    (mem_cmd_ready_o),
        .mem_resp_o         (mem_resp_o),
        .mem_resp_v_o       (mem_resp_v_o),
        .mem_resp_yumi_i    (mem_resp_yumi_i),
        .io_cmd_i           (io_cmd_i),
        .io_cmd_v_i         (io_cmd_v_i),
        .io_cmd_ready_o     (io_cmd_ready_o),
        .io_resp_o          (io_resp_o),
        .io_resp_v_o        (io_resp_v_o),
        .io_resp_yumi_i     (io_resp_yumi_i),
        .shared_cmd_o       (shared_cmd_o),
        .shared_cmd_v_o     (shared_cmd_v_o),
        .shared_cmd_ready_i (shared_cmd_ready_i),
        .shared_resp_i      (shared_resp_i),
        .shared_resp_v_i    (shared_resp_v_i),
        .shared_resp_yumi_o (shared_resp_yumi_o),
        .outstanding_o      (outstanding_o),
        .error_o            (error_o)
    );

    // Reference model state
    int           m_last;
    bit           m_q[$];
    bit           m_slot_v;
    logic [W-1:0] m_slot_d;
    bit           m_err;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        mem_cmd_v_i = 1'b0; io_cmd_v_i = 1'b0; shared_cmd_ready_i = 1'b0;
        shared_resp_v_i = 1'b0; mem_resp_yumi_i = 1'b0; io_resp_yumi_i = 1'b0;
        mem_cmd_i = '0; io_cmd_i = '0; shared_resp_i = '0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i  = 1'b0;
        m_last   = 1;
        m_q.delete();
        m_slot_v = 1'b0;
        m_slot_d = '0;
        m_err    = 1'b0;
    endtask

    // One clock cycle: drive, check every output against the model, advance model.
    task automatic step(input bit v0, input bit v1, input bit srdy,
                        input bit rv, input bit y0, input bit y1);
        int g;
        bit slot_free, credit, e_r0, e_r1, e_mv, e_iv, e_y, head, pop, drop;
        mem_cmd_i          = W'($urandom);
        io_cmd_i           = W'($urandom);
        shared_resp_i      = W'($urandom);
        mem_cmd_v_i        = v0;
        io_cmd_v_i         = v1;
        shared_cmd_ready_i = srdy;
        shared_resp_v_i    = rv;
        mem_resp_yumi_i    = y0;
        io_resp_yumi_i     = y1;
        #1;
        slot_free = !m_slot_v || srdy;
        credit    = m_q.size() < MAXO;
        g = -1;
        if (v0 && v1)  g = (m_last == 0) ? 1 : 0;
        else if (v0)   g = 0;
        else if (v1)   g = 1;
        e_r0 = (g == 0) && slot_free && credit;
        e_r1 = (g == 1) && slot_free && credit;
        e_mv = 0; e_iv = 0; e_y = 0; pop = 0; drop = 0;
        if (rv) begin
            if (m_q.size() == 0) begin
                e_y  = 1;
                drop = 1;
            end else begin
                head = m_q[0];
                if (!head) begin e_mv = 1; e_y = y0; end
                else       begin e_iv = 1; e_y = y1; end
                pop = e_y;
            end
        end
        check_val("mem_cmd_ready", mem_cmd_ready_o, e_r0);
        check_val("io_cmd_ready", io_cmd_ready_o, e_r1);
        check_val("mem_resp_v", mem_resp_v_o, e_mv);
        check_val("io_resp_v", io_resp_v_o, e_iv);
        check_val("shared_resp_yumi", shared_resp_yumi_o, e_y);
        check_val("shared_cmd_v", shared_cmd_v_o, m_slot_v);
        if (m_slot_v) check_val("shared_cmd", shared_cmd_o, m_slot_d);
        if (e_mv) check_val("mem_resp_data", mem_resp_o, shared_resp_i);
        if (e_iv) check_val("io_resp_data", io_resp_o, shared_resp_i);
        check_val("outstanding", outstanding_o, m_q.size());
        check_val("error", error_o, m_err);
        // advance model
        if (pop) void'(m_q.pop_front());
        if (drop) m_err = 1;
        if (e_r0 || e_r1) begin
            m_slot_v = 1;
            m_slot_d = (g == 0) ? mem_cmd_i : io_cmd_i;
            m_q.push_back(g == 1);
            m_last = g;
        end else if (srdy) begin
            m_slot_v = 0;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        repeat (12) step(1'b0, 1'b0, 1'b1, m_q.size() > 0, 1'b1, 1'b1);
    endtask

    initial begin
        reset_i = 1'b1;
        do_reset();
        // reset state
        check_val("rst_shared_cmd_v", shared_cmd_v_o, 1'b0);
        check_val("rst_outstanding", outstanding_o, 0);
        check_val("rst_error", error_o, 1'b0);

        // both ports constantly valid: alternating grants, starting at port 0
        repeat (8) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();

        // port 1 only, three commands then three responses
        repeat (3) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        drain();

        // credit exhaustion, then one response frees a credit
        repeat (6) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        drain();

        // downstream stalled: slot holds, no new accepts
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        drain();

        // accept and response consumed in the same cycle at two outstanding
        repeat (2) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        check_val("same_cycle_outstanding", outstanding_o, 2);
        drain();

        // randomized traffic, responses only while commands are in flight
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom), 1'($urandom), ($urandom % 4) != 0,
                 (m_q.size() > 0) && 1'($urandom), 1'($urandom), 1'($urandom));
        end
        drain();

        // response with no tag: dropped and flagged until reset
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b1, m_q.size() > 0, 1'b1, 1'b1);
        check_val("error_sticky", error_o, 1'b1);
        do_reset();
        check_val("error_cleared", error_o, 1'b0);
        check_val("post_rst_outstanding", outstanding_o, 0);
        repeat (4) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
